// File: rtl/logit_vote_classifier.sv
// logit_vote_classifier
//   Sequential argmax over NUM_CLASSES signed logits with runner-up, margin, low-confidence
//   flag and a sliding-window majority vote over the most recent predictions.
//
// Ports
//   clk               clock
//   rst_n             synchronous active-low reset
//   i_valid/i_ready   frame handshake; i_ready is high only while idle
//   i_logits          packed logits, class k at [k*DATA_WIDTH +: DATA_WIDTH], signed
//   o_valid/o_ready   result handshake
//   o_predicted_class argmax of the frame (ties -> lower index)
//   o_runner_up       second-best class (ties -> lower index)
//   o_margin          best - second, unsigned, DATA_WIDTH+1 bits
//   o_low_conf        o_margin <= MARGIN_THRESH
//   o_vote_class      class with the highest count in the vote history (ties -> lower index)
//   o_vote_full       history holds VOTE_WINDOW frames
//   i_clear_votes     synchronous clear of the vote history, wins over a coincident update
module logit_vote_classifier #(
  parameter int unsigned NUM_CLASSES       = 3,
  parameter int unsigned DATA_WIDTH        = 16,
  parameter int unsigned CLASS_WIDTH       = 2,
  parameter int unsigned MARGIN_THRESH     = 0,
  parameter int unsigned VOTE_WINDOW       = 4,
  parameter int unsigned VOTE_SKIP_LOWCONF = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_valid,
  output logic                              i_ready,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] i_logits,
  output logic                              o_valid,
  input  logic                              o_ready,
  output logic [CLASS_WIDTH-1:0]            o_predicted_class,
  output logic [CLASS_WIDTH-1:0]            o_runner_up,
  output logic [DATA_WIDTH:0]               o_margin,
  output logic                              o_low_conf,
  output logic [CLASS_WIDTH-1:0]            o_vote_class,
  output logic                              o_vote_full,
  input  logic                              i_clear_votes
);

  localparam int unsigned CntW   = $clog2(VOTE_WINDOW + 1);
  localparam int unsigned FrameW = NUM_CLASSES * DATA_WIDTH;

  typedef enum logic [1:0] {StIdle, StScan, StOut} state_e;

  state_e state_q, state_d;

  logic [FrameW-1:0]             frame_q, frame_d;
  logic [CLASS_WIDTH-1:0]        idx_q, idx_d;
  logic [CLASS_WIDTH-1:0]        best_q, best_d, second_q, second_d;
  logic signed [DATA_WIDTH-1:0]  best_val_q, best_val_d, second_val_q, second_val_d;
  logic                          best_vld_q, best_vld_d, second_vld_q, second_vld_d;

  logic [CLASS_WIDTH-1:0]        pred_q, pred_d, runner_q, runner_d;
  logic [DATA_WIDTH:0]           margin_q, margin_d;
  logic                          low_conf_q, low_conf_d;

  logic [CLASS_WIDTH-1:0]        hist_q [VOTE_WINDOW];
  logic [CLASS_WIDTH-1:0]        hist_d [VOTE_WINDOW];
  logic [CntW-1:0]               fill_q, fill_d;
  logic [CntW-1:0]               cnt_q [NUM_CLASSES];
  logic [CntW-1:0]               cnt_d [NUM_CLASSES];

  logic signed [DATA_WIDTH-1:0]  cur_val;
  logic                          accept, scan_last, hist_full, vote_push;
  logic [DATA_WIDTH:0]           margin_calc;
  logic                          low_conf_calc;
  logic [CLASS_WIDTH-1:0]        oldest;
  logic [CLASS_WIDTH-1:0]        vote_class;
  logic [CntW-1:0]               vote_max;

  assign i_ready   = (state_q == StIdle);
  assign o_valid   = (state_q == StOut);
  assign accept    = i_valid && i_ready;
  assign scan_last = (state_q == StScan) && (idx_q == CLASS_WIDTH'(NUM_CLASSES - 1));
  assign cur_val   = frame_q[int'(idx_q) * DATA_WIDTH +: DATA_WIDTH];
  assign hist_full = (fill_q == CntW'(VOTE_WINDOW));
  assign oldest    = hist_q[VOTE_WINDOW-1];

  // Sign-extend both operands so best - second never overflows.
  assign margin_calc   = {best_val_d[DATA_WIDTH-1], best_val_d}
                       - {second_val_d[DATA_WIDTH-1], second_val_d};
  assign low_conf_calc = (margin_calc <= (DATA_WIDTH + 1)'(MARGIN_THRESH));
  assign vote_push     = scan_last && !((VOTE_SKIP_LOWCONF != 0) && low_conf_calc);

  // FSM and scan datapath
  always_comb begin
    state_d      = state_q;
    frame_d      = frame_q;
    idx_d        = idx_q;
    best_d       = best_q;
    best_val_d   = best_val_q;
    best_vld_d   = best_vld_q;
    second_d     = second_q;
    second_val_d = second_val_q;
    second_vld_d = second_vld_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d      = StScan;
          frame_d      = i_logits;
          idx_d        = '0;
          best_vld_d   = 1'b0;
          second_vld_d = 1'b0;
        end
      end
      StScan: begin
        // Strict compares keep the lower index on ties.
        if (!best_vld_q || (cur_val > best_val_q)) begin
          second_d     = best_q;
          second_val_d = best_val_q;
          second_vld_d = best_vld_q;
          best_d       = idx_q;
          best_val_d   = cur_val;
          best_vld_d   = 1'b1;
        end else if (!second_vld_q || (cur_val > second_val_q)) begin
          second_d     = idx_q;
          second_val_d = cur_val;
          second_vld_d = 1'b1;
        end
        idx_d = idx_q + CLASS_WIDTH'(1);
        if (scan_last) begin
          state_d = StOut;
        end
      end
      StOut: begin
        if (o_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Result registers load on the SCAN->OUT edge and hold otherwise.
  always_comb begin
    pred_d     = pred_q;
    runner_d   = runner_q;
    margin_d   = margin_q;
    low_conf_d = low_conf_q;
    if (scan_last) begin
      pred_d     = best_d;
      runner_d   = second_d;
      margin_d   = margin_calc;
      low_conf_d = low_conf_calc;
    end
  end

  // Vote history: newest at index 0, oldest at VOTE_WINDOW-1 once full.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    if (i_clear_votes) begin
      for (int i = 0; i < int'(VOTE_WINDOW); i++) hist_d[i] = '0;
      for (int k = 0; k < int'(NUM_CLASSES); k++) cnt_d[k] = '0;
      fill_d = '0;
    end else if (vote_push) begin
      hist_d[0] = best_d;
      for (int i = 1; i < int'(VOTE_WINDOW); i++) hist_d[i] = hist_q[i-1];
      if (!hist_full) begin
        fill_d = fill_q + CntW'(1);
      end
      for (int k = 0; k < int'(NUM_CLASSES); k++) begin
        if ((best_d == CLASS_WIDTH'(k)) && !(hist_full && (oldest == CLASS_WIDTH'(k)))) begin
          cnt_d[k] = cnt_q[k] + CntW'(1);
        end else if ((best_d != CLASS_WIDTH'(k)) && hist_full &&
                     (oldest == CLASS_WIDTH'(k))) begin
          cnt_d[k] = cnt_q[k] - CntW'(1);
        end
      end
    end
  end

  // Majority from registered counts, lower index wins ties.
  always_comb begin
    vote_class = '0;
    vote_max   = cnt_q[0];
    for (int k = 1; k < int'(NUM_CLASSES); k++) begin
      if (cnt_q[k] > vote_max) begin
        vote_max   = cnt_q[k];
        vote_class = CLASS_WIDTH'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      frame_q      <= '0;
      idx_q        <= '0;
      best_q       <= '0;
      best_val_q   <= '0;
      best_vld_q   <= 1'b0;
      second_q     <= '0;
      second_val_q <= '0;
      second_vld_q <= 1'b0;
      pred_q       <= '0;
      runner_q     <= '0;
      margin_q     <= '0;
      low_conf_q   <= 1'b0;
      hist_q       <= '{default: '0};
      fill_q       <= '0;
      cnt_q        <= '{default: '0};
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      idx_q        <= idx_d;
      best_q       <= best_d;
      best_val_q   <= best_val_d;
      best_vld_q   <= best_vld_d;
      second_q     <= second_d;
      second_val_q <= second_val_d;
      second_vld_q <= second_vld_d;
      pred_q       <= pred_d;
      runner_q     <= runner_d;
      margin_q     <= margin_d;
      low_conf_q   <= low_conf_d;
      hist_q       <= hist_d;
      fill_q       <= fill_d;
      cnt_q        <= cnt_d;
    end
  end

  assign o_predicted_class = pred_q;
  assign o_runner_up       = runner_q;
  assign o_margin          = margin_q;
  assign o_low_conf        = low_conf_q;
  assign o_vote_class      = vote_class;
  assign o_vote_full       = hist_full;

endmodule
